// File: rtl/fixed_sub_pipe_if.sv
// Stream bundle for fixed_sub_pipe: operand handshake, result handshake and event counters.
// The slave modport is the subtractor side; master is the producer/consumer side.
interface fixed_sub_pipe_if #(
  parameter int data_width = 16,
  parameter int cnt_width  = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] a_in;
  logic [data_width-1:0] b_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] diff_out;
  logic                  overflow_flag;
  logic                  underflow_flag;
  logic                  clear_counts;
  logic [cnt_width-1:0]  ovf_count;
  logic [cnt_width-1:0]  unf_count;

  modport slave (
    input  in_valid, a_in, b_in, out_ready, clear_counts,
    output in_ready, out_valid, diff_out, overflow_flag, underflow_flag,
           ovf_count, unf_count
  );

  modport master (
    output in_valid, a_in, b_in, out_ready, clear_counts,
    input  in_ready, out_valid, diff_out, overflow_flag, underflow_flag,
           ovf_count, unf_count
  );

endinterface

// File: rtl/fixed_sub_pipe.sv
// Two-stage signed fixed-point subtractor (a - b) with saturation, clip flags and event counters.
// Define FIXED_SUB_WRAP_EN to replace saturation with modular wrap (flags/counters unchanged).
module fixed_sub_pipe #(
  parameter int data_width = 16,
  parameter int frac_width = 14,
  parameter int int_width  = 2,
  parameter int cnt_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_sub_pipe_if.slave       bus
);

  if (data_width != int_width + frac_width) begin : g_bad_format
    $error("fixed_sub_pipe: data_width must equal int_width + frac_width");
  end

  logic [data_width:0]   a_ext;
  logic [data_width:0]   b_ext;
  logic [data_width:0]   ext_diff;

  logic                  s2_load;
  logic                  s1_load;
  logic                  out_fire;

  logic                  s1_valid_q, s1_valid_d;
  logic [data_width:0]   s1_diff_q, s1_diff_d;

  logic                  sat_hi;
  logic                  sat_lo;
  logic [data_width-1:0] sat_val;

  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] diff_q, diff_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [cnt_width-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [cnt_width-1:0]  unf_cnt_q, unf_cnt_d;

  // One guard bit makes the difference exact; stall control flows backwards from out_ready.
  always_comb begin
    a_ext    = {bus.a_in[data_width-1], bus.a_in};
    b_ext    = {bus.b_in[data_width-1], bus.b_in};
    ext_diff = a_ext - b_ext;
    s2_load  = !out_valid_q || bus.out_ready;
    s1_load  = !s1_valid_q || s2_load;
    out_fire = out_valid_q && bus.out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_diff_d  = s1_diff_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_diff_d = ext_diff;
      end
    end
  end

  // Guard and sign bits disagree exactly when the result leaves the data_width range.
  always_comb begin
    sat_hi = !s1_diff_q[data_width] &&  s1_diff_q[data_width-1];
    sat_lo =  s1_diff_q[data_width] && !s1_diff_q[data_width-1];
`ifdef FIXED_SUB_WRAP_EN
    sat_val = s1_diff_q[data_width-1:0];
`else
    if (sat_hi) begin
      sat_val = {1'b0, {(data_width-1){1'b1}}};
    end else if (sat_lo) begin
      sat_val = {1'b1, {(data_width-1){1'b0}}};
    end else begin
      sat_val = s1_diff_q[data_width-1:0];
    end
`endif
  end

  // Result and flags only change when a valid S1 entry moves in, so they hold when idle.
  always_comb begin
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = sat_val;
        ovf_d  = sat_hi;
        unf_d  = sat_lo;
      end
    end
  end

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (bus.clear_counts) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (out_fire && ovf_q && (ovf_cnt_q != {cnt_width{1'b1}})) begin
        ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
      if (out_fire && unf_q && (unf_cnt_q != {cnt_width{1'b1}})) begin
        unf_cnt_d = unf_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  assign bus.in_ready       = s1_load;
  assign bus.out_valid      = out_valid_q;
  assign bus.diff_out       = diff_q;
  assign bus.overflow_flag  = ovf_q;
  assign bus.underflow_flag = unf_q;
  assign bus.ovf_count      = ovf_cnt_q;
  assign bus.unf_count      = unf_cnt_q;

endmodule

// File: tb/tb_fixed_sub_pipe.sv
// Scoreboard bench for fixed_sub_pipe: accepted operand pairs queue an integer-arithmetic
// reference result; a negedge monitor checks every presented result and both counters.
module tb_fixed_sub_pipe;

  localparam int DW     = 16;
  localparam int CW     = 8;
  localparam int MaxPos = (1 << (DW - 1)) - 1;
  localparam int MinNeg = -(1 << (DW - 1));
  localparam int CntMax = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  logic [DW+1:0] expQ[$];
  int modelOvf;
  int modelUnf;

  fixed_sub_pipe_if #(.data_width(DW), .cnt_width(CW)) bus ();

  fixed_sub_pipe #(
    .data_width(DW),
    .frac_width(14),
    .int_width (2),
    .cnt_width (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer difference, then clip or wrap; returns {ovf, unf, diff}.
  function automatic logic [DW+1:0] refSub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int d;
    logic [31:0] dv;
    logic ovf;
    logic unf;
    logic [DW-1:0] r;
    d   = int'($signed(a)) - int'($signed(b));
    dv  = d;
    ovf = (d > MaxPos);
    unf = (d < MinNeg);
    r   = dv[DW-1:0];
`ifndef FIXED_SUB_WRAP_EN
    if (ovf) r = {1'b0, {(DW-1){1'b1}}};
    if (unf) r = {1'b1, {(DW-1){1'b0}}};
`endif
    return {ovf, unf, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: check presented results against the queue head, track counters, record accepts.
  always @(negedge clk) begin
    logic [DW+1:0] expVal;
    if (!rst_n) begin
      expQ.delete();
      modelOvf = 0;
      modelUnf = 0;
      checkOutput("reset_out_valid", bus.out_valid, 0);
    end else begin
      checkOutput("ovf_count", bus.ovf_count, modelOvf);
      checkOutput("unf_count", bus.unf_count, modelUnf);
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_valid", bus.out_valid, 0);
        end else begin
          expVal = expQ[0];
          checkOutput("diff_out", bus.diff_out, expVal[DW-1:0]);
          checkOutput("overflow_flag", bus.overflow_flag, expVal[DW+1]);
          checkOutput("underflow_flag", bus.underflow_flag, expVal[DW]);
          if (bus.out_ready) begin
            void'(expQ.pop_front());
            if (expVal[DW+1] && modelOvf < CntMax) modelOvf++;
            if (expVal[DW] && modelUnf < CntMax) modelUnf++;
          end
        end
      end
      if (bus.clear_counts) begin
        modelOvf = 0;
        modelUnf = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(refSub(bus.a_in, bus.b_in));
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_done", (expQ.size() == 0 && !bus.out_valid), 1);
  endtask

  function automatic logic [DW-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hC000;
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin
    logic [DW-1:0] bpA[4];
    logic [DW-1:0] bpB[4];
    int idx;
    logic acc;

    checks = 0;
    errors = 0;
    modelOvf = 0;
    modelUnf = 0;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.a_in         = '0;
    bus.b_in         = '0;
    bus.out_ready    = 1'b1;
    bus.clear_counts = 1'b0;

    #2;
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_ovf_count", bus.ovf_count, 0);
    checkOutput("reset_diff_out", bus.diff_out, 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] normal subtraction, latency");
    applyStimulus(16'h4000, 16'h3000);
    checkOutput("latency_early", bus.out_valid, 0);
    @(posedge clk); #1;
    checkOutput("latency_valid", bus.out_valid, 1);
    checkOutput("normal_diff", bus.diff_out, 16'h1000);
    checkOutput("normal_flags", {bus.overflow_flag, bus.underflow_flag}, 0);
    waitDrain(20);

    $display("[TB] overflow");
    applyStimulus(16'h7FFF, 16'hC000);
    @(posedge clk); #1;
`ifdef FIXED_SUB_WRAP_EN
    checkOutput("ovf_diff", bus.diff_out, 16'hBFFF);
`else
    checkOutput("ovf_diff", bus.diff_out, 16'h7FFF);
`endif
    checkOutput("ovf_flag", bus.overflow_flag, 1);
    checkOutput("ovf_count_before", bus.ovf_count, 0);
    waitDrain(20);
    checkOutput("ovf_count_after", bus.ovf_count, 1);

    $display("[TB] underflow and min-minus-min");
    applyStimulus(16'h8000, 16'h0001);
    @(posedge clk); #1;
`ifdef FIXED_SUB_WRAP_EN
    checkOutput("unf_diff", bus.diff_out, 16'h7FFF);
`else
    checkOutput("unf_diff", bus.diff_out, 16'h8000);
`endif
    checkOutput("unf_flag", bus.underflow_flag, 1);
    waitDrain(20);
    checkOutput("unf_count_after", bus.unf_count, 1);
    applyStimulus(16'h8000, 16'h8000);
    @(posedge clk); #1;
    checkOutput("edge_diff", bus.diff_out, 16'h0000);
    checkOutput("edge_flags", {bus.overflow_flag, bus.underflow_flag}, 0);
    waitDrain(20);

    $display("[TB] backpressure");
    bpA = '{16'h1000, 16'h7FFF, 16'h8000, 16'h0123};
    bpB = '{16'h0800, 16'h8000, 16'h7FFF, 16'h0456};
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) begin
        bus.in_valid = 1'b1;
        bus.a_in     = bpA[idx];
        bus.b_in     = bpB[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (idx == 2) checkOutput("bp_in_ready_low", bus.in_ready, 0);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    checkOutput("bp_accepts", idx, 2);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = bpA[idx];
      bus.b_in     = bpB[idx];
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    checkOutput("bp_all_accepted", idx, 4);
    waitDrain(20);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.a_in         = pickOperand();
      bus.b_in         = pickOperand();
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      bus.clear_counts = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.clear_counts = 1'b0;
    waitDrain(50);

    $display("[TB] counter saturation and clear");
    for (int k = 0; k < 260; k++) begin
      applyStimulus(16'h7FFF, 16'hC000);
    end
    waitDrain(20);
    checkOutput("ovf_saturated", bus.ovf_count, CntMax);
    applyStimulus(16'h7FFF, 16'hC000);
    @(posedge clk); #1;
    checkOutput("clear_out_valid", bus.out_valid, 1);
    bus.clear_counts = 1'b1;
    @(posedge clk); #1;
    bus.clear_counts = 1'b0;
    checkOutput("ovf_cleared", bus.ovf_count, 0);
    waitDrain(20);

    $display("[TB] reset with results in flight");
    applyStimulus(16'h8000, 16'h0001);
    waitDrain(20);
    checkOutput("pre_reset_unf", bus.unf_count, 1);
    bus.out_ready = 1'b0;
    applyStimulus(16'h0100, 16'h0050);
    applyStimulus(16'h0200, 16'h0010);
    checkOutput("inflight_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", bus.out_valid, 0);
    checkOutput("async_in_ready", bus.in_ready, 1);
    checkOutput("async_ovf_count", bus.ovf_count, 0);
    checkOutput("async_unf_count", bus.unf_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", bus.out_valid, 0);
    applyStimulus(16'h2000, 16'h6000);
    waitDrain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fixed_sub_pipe.md
Name: fixed_sub_pipe

Overview:
- Pipelined signed fixed-point subtractor: diff_out = a_in - b_in, saturating, Qint_width.frac_width format.
- Inverse-direction companion to the combinational fixed-point adder.
- Sits in the streaming datapath behind a valid/ready handshake on both sides.
- Reports per-result overflow/underflow flags and keeps saturating event counters.

Parameters:
- data_width, 16, total word width (two's complement); must equal int_width + frac_width.
- frac_width, 14, fractional bits.
- int_width, 2, integer bits including sign.
- cnt_width, 8, width of the overflow/underflow event counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a_in/b_in valid.
- in_ready  output  1  block accepts the operand pair this cycle.
- a_in  input  data_width  minuend, signed.
- b_in  input  data_width  subtrahend, signed.
- out_valid  output  1  diff_out and flags valid.
- out_ready  input  1  downstream accepts the result.
- diff_out  output  data_width  result, signed.
- overflow_flag  output  1  result clipped high; qualified by out_valid.
- underflow_flag  output  1  result clipped low; qualified by out_valid.
- clear_counts  input  1  synchronous clear of both counters.
- ovf_count  output  cnt_width  overflow results delivered.
- unf_count  output  cnt_width  underflow results delivered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pipeline valids, diff_out, flags and counters go to 0.
  - in_ready is 1 after reset.
  - In-flight data is discarded.
- Handshake:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - diff_out and flags hold stable while out_valid && !out_ready.
- Pipeline:
  - S1 registers the sign-extended data_width+1-bit difference.
  - S2 saturates and registers diff_out and the flags.
  - Latency is exactly 2 cycles from input accept to out_valid with no stall.
  - Throughput is 1 per cycle.
- Stall rules:
  - S2 loads when !out_valid || out_ready.
  - S1 loads when !s1_valid || S2 loads.
  - in_ready = !s1_valid || S2 loads (combinational from out_ready).
  - The pipeline holds 2 results maximum; no drops, no duplicates.
- Arithmetic:
  - Both operands are sign-extended by 1 bit before subtracting.
  - Ext > 2^(data_width-1)-1: diff_out = 0x7FFF (default), overflow_flag = 1.
  - Ext < -2^(data_width-1): diff_out = 0x8000, underflow_flag = 1.
  - Otherwise diff_out = ext[data_width-1:0] with both flags 0.
  - Flags are mutually exclusive. No rounding, since the binary point is unchanged.
- Counters:
  - Increment on the output transfer of a result whose respective flag is set.
  - Saturate at 2^cnt_width-1; no wrap.
  - clear_counts has priority over a same-cycle increment, giving 0.
- Empty: out_valid stays 0 and diff_out/flags hold their last values.

Optional Feature:
- Macro FIXED_SUB_WRAP_EN.
- Defined: no saturation; diff_out = ext[data_width-1:0] (modular wrap). overflow_flag, underflow_flag and the counters behave exactly as without the macro.
- Undefined (default): saturating behaviour as above.

Test Plan:
- Normal, no stall: a=0x4000 (1.0), b=0x3000 (0.75).
  - Expect out_valid 2 cycles later, diff_out=0x1000 (0.25), both flags 0.
- Overflow: a=0x7FFF, b=0xC000 (-1.0).
  - Expect diff_out=0x7FFF, overflow_flag=1, ovf_count 0->1 on the transfer.
  - With FIXED_SUB_WRAP_EN: diff_out=0xBFFF, flag still 1.
- Underflow and edge: a=0x8000, b=0x0001 -> diff_out=0x8000, underflow_flag=1, unf_count=1. Then a=0x8000, b=0x8000 -> diff_out=0x0000, flags 0.
- Backpressure:
  - Stream 4 pairs back-to-back with out_ready=0 for 5 cycles.
  - Expect in_ready=0 after 2 accepts and diff_out stable while stalled.
  - After out_ready=1, all 4 results arrive in order, none lost or duplicated.
- Counter saturation and clear:
  - 260 overflow results -> ovf_count=255.
  - Assert clear_counts on the same cycle as another overflow transfer -> ovf_count=0.
- Reset mid-operation:
  - Drop rst_n asynchronously while 2 results are in flight and out_ready=0.
  - Expect out_valid=0, counters=0, in_ready=1 immediately.
  - No stale result appears after release.
